// File: rtl/mem_access_pkg.sv
// Shared types and widths for the load/store sequencer in front of the 256x16 data RAM.
package mem_access_pkg;

    localparam int unsigned MAU_ADDR_W    = 16;
    localparam int unsigned MAU_DATA_W    = 16;
    localparam int unsigned MAU_RD_W      = 4;
    localparam int unsigned MAU_MEM_WORDS = 256;
    localparam int unsigned RAM_IDX_W     = $clog2(MAU_MEM_WORDS);
    localparam int unsigned RAM_PORT_W    = 17;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } mau_state_e;

    typedef struct packed {
        logic                  we;
        logic [MAU_ADDR_W-1:0] addr;
        logic [MAU_DATA_W-1:0] wdata;
        logic [MAU_RD_W-1:0]   rd;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO of mem_req_t with full/empty flags; DEPTH must be a power of 2.
module mem_req_fifo
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  mem_req_t push_data_i,
    input  logic     pop_i,
    output mem_req_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    mem_req_t      mem_q [DEPTH];
    mem_req_t      mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = push_data_i;
            wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// In-order load/store sequencer driving the data RAM; one op in flight, results returned to writeback.
// Define ADDR_RANGE_CHECK_EN to suppress and flag accesses at or above MEM_WORDS.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = MAU_ADDR_W,
    parameter int unsigned MEM_WORDS  = MAU_MEM_WORDS,
    parameter int unsigned RD_W       = MAU_RD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [15:0]           req_wdata,
    input  logic [RD_W-1:0]       req_rd,
    output logic [RAM_PORT_W-1:0] ram_addr,
    output logic [RAM_PORT_W-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [RAM_PORT_W-1:0] ram_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [15:0]           wb_data,
    output logic [RD_W-1:0]       wb_rd,
    output logic                  wb_err,
    output logic                  err_sticky,
    output logic                  busy
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    mau_state_e          state_q, state_d;
    mem_req_t            op_q, op_d;
    logic                wb_valid_q, wb_valid_d;
    logic [15:0]         wb_data_q, wb_data_d;
    logic [MAU_RD_W-1:0] wb_rd_q, wb_rd_d;
    logic                wb_err_q, wb_err_d;
    logic                err_sticky_q, err_sticky_d;

    mem_req_t fifo_in;
    mem_req_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     op_oor;

    assign fifo_in.we    = req_we;
    assign fifo_in.addr  = MAU_ADDR_W'(req_addr);
    assign fifo_in.wdata = req_wdata;
    assign fifo_in.rd    = MAU_RD_W'(req_rd);

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef ADDR_RANGE_CHECK_EN
    localparam logic [MAU_ADDR_W:0] MemWordsExt = (MAU_ADDR_W + 1)'(MEM_WORDS);
    assign op_oor = ({1'b0, op_q.addr} >= MemWordsExt);
`else
    assign op_oor = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wb_valid_d   = wb_valid_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        wb_err_d     = wb_err_q;
        err_sticky_d = err_sticky_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    op_d    = fifo_head;
                    state_d = StExec;
                end
            end
            StExec: begin
                err_sticky_d = err_sticky_q | op_oor;
                if (op_q.we) begin
                    state_d = StIdle;
                end else begin
                    wb_data_d  = op_oor ? 16'h0000 : ram_rdata[15:0];
                    wb_rd_d    = op_q.rd;
                    wb_err_d   = op_oor;
                    wb_valid_d = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_err_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_err_q     <= wb_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // RAM pins come straight from the op register so they hold between ops.
    assign ram_addr   = RAM_PORT_W'(op_q.addr[IdxW-1:0]);
    assign ram_wdata  = {1'b0, op_q.wdata};
    assign ram_we     = (state_q == StExec) && op_q.we && !op_oor;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = RD_W'(wb_rd_q);
    assign wb_err     = wb_err_q;
    assign err_sticky = err_sticky_q;
    assign busy       = !fifo_empty || (state_q != StIdle);

    logic unused_bits;
    assign unused_bits = ^{ram_rdata[RAM_PORT_W-1], op_q.addr[MAU_ADDR_W-1:IdxW]};

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 256x16 data RAM (ram_1).
- Accepts memory ops from execute through a valid/ready queue and drives the RAM's address, write-data and write-enable pins.
- Returns load data, tagged with its destination register, to register-file writeback over a valid/ready handshake.
- Guarantees strict program order and one RAM access per cycle.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, >=2).
- ADDR_W, 16, request address width (register-derived).
- MEM_WORDS, 256, RAM words; RAM index = low log2(MEM_WORDS) address bits.
- RD_W, 4, destination register tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  store data.
- req_rd  in  RD_W  load destination register.
- ram_addr  out  17  to RAM address pin, zero-extended index.
- ram_wdata  out  17  to RAM write-data pin, {1'b0,data}.
- ram_we  out  1  to RAM write enable.
- ram_rdata  in  17  RAM read data; bits [15:0] used.
- wb_valid  out  1  load result valid.
- wb_ready  in  1  writeback accepts.
- wb_data  out  16  load result.
- wb_rd  out  RD_W  load tag.
- wb_err  out  1  result from out-of-range load.
- err_sticky  out  1  any out-of-range access since reset.
- busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0): queue empty, state IDLE. All outputs 0 except req_ready=1. ram_we drops immediately; an in-flight store is abandoned.
- Queue:
  - Push on req_valid&&req_ready.
  - req_ready = !full, evaluated from current-cycle state only: a full queue rejects even when popping in the same cycle.
  - Push and pop in one cycle are allowed when not full.
  - Pointers wrap mod FIFO_DEPTH.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if queue non-empty, pop head into op register, go EXEC; else stay.
  - EXEC, store: ram_we=1 for exactly this cycle, ram_addr=index, ram_wdata={1'b0,wdata}; next IDLE.
  - EXEC, load: ram_we=0, ram_addr=index; at the clock edge capture ram_rdata[15:0] into wb_data and op rd into wb_rd, set wb_valid; next RESP.
  - RESP: hold wb_valid/wb_data/wb_rd/wb_err stable until wb_valid&&wb_ready; then clear wb_valid, go IDLE.
- Outside EXEC: ram_we=0; ram_addr/ram_wdata hold the last op's values (no glitching, driven from flops).
- Latency from acceptance into an empty queue:
  - store: RAM written 2 cycles after acceptance.
  - load: wb_valid 3 cycles after acceptance.
  - store throughput: 1 per 2 cycles; load throughput: 1 per 3 cycles minimum.
- Ordering: FIFO order, one op at a time. A load after a store to the same address returns the stored value.
- Backpressure: wb_ready low stalls the FSM in RESP; the queue keeps accepting until full.

Optional Feature:
- Macro ADDR_RANGE_CHECK_EN.
- Defined:
  - req_addr >= MEM_WORDS marks the op out-of-range.
  - Out-of-range store: EXEC cycle with ram_we=0, no write.
  - Out-of-range load: wb_data=16'h0000, wb_err=1.
  - Any out-of-range op sets err_sticky until reset.
- Undefined: address truncated to the low log2(MEM_WORDS) bits; wb_err and err_sticky tied 0. Ports exist in both builds.

Decomposition:
- Package mem_access_pkg holds:
  - FSM state enum.
  - mem_req_t struct {we, addr, wdata, rd}.
  - RAM index width localparam.
  - RAM port width constant 17.
- Sub-module mem_req_fifo: parameterised synchronous FIFO of mem_req_t with full/empty flags and async active-low reset.

Test Plan:
- Store then load: store 16'h1234 @0x0010, then load @0x0010 rd=3 -> ram_we high exactly one cycle with ram_addr=17'h00010, ram_wdata=17'h01234; wb_valid with wb_data=16'h1234, wb_rd=3.
- Queue full: wb_ready=0, offer 6 loads back-to-back -> 5 accepted (1 in RESP + 4 queued), req_ready low on the 6th; raising wb_ready drains all 5 in order with matching tags.
- Backpressure stability: hold wb_ready=0 for 3 cycles during RESP -> wb_data/wb_rd unchanged, no ram_we pulses, busy=1.
- Mixed ordering: store 0xAAAA @5, load @5, store 0x5555 @5, load @5 -> results 0xAAAA then 0x5555.
- Range check, ADDR_RANGE_CHECK_EN set: store @0x0100 -> no ram_we; load @0x0100 -> wb_data=0, wb_err=1, err_sticky=1. Without the macro: load @0x0100 reads index 0x00.
- Async reset in RESP: drop rst_n between edges -> wb_valid=0, ram_we=0, req_ready=1, busy=0 immediately. After release the first new load completes normally.
